// File: rtl/ahbl_excl_monitor.sv
// ahbl_excl_monitor: AHB-Lite exclusive monitor between the N:1 arbiter and a shared slave.
// Holds one reservation per master and completes failing exclusive stores locally with zero wait.
module ahbl_excl_monitor #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int N_MASTERS = 2,
  parameter int GRAN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [3:0]        src_hprot,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [3:0]        dst_hprot,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);
  localparam int W_IDX = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  localparam int W_G   = W_ADDR - GRAN_LOG2;

  logic [N_MASTERS-1:0] resv_valid_q, resv_valid_d;
  logic [W_G-1:0]       resv_gran_q [N_MASTERS];
  logic [W_G-1:0]       resv_gran_d [N_MASTERS];
  logic                 dp_active_q, dp_active_d, dp_local_q, dp_local_d;
  logic                 dp_excl_ok_q, dp_excl_ok_d, dp_excl_rd_q, dp_excl_rd_d;
  logic [W_IDX-1:0]     dp_master_q, dp_master_d;
  logic                 acc, m_ok, pass, ex_rd, ex_wr, nm_wr, err_clr;
  logic [W_IDX-1:0]     m;
  logic [W_G-1:0]       g;

  assign acc   = src_hready & src_htrans[1];
  assign m     = src_hmaster[W_IDX-1:0];
  assign m_ok  = 32'(src_hmaster) < N_MASTERS;
  assign g     = src_haddr[W_ADDR-1:GRAN_LOG2];
  assign ex_rd = acc & src_hexcl & ~src_hwrite;
  assign ex_wr = acc & src_hexcl & src_hwrite;
  assign nm_wr = acc & ~src_hexcl & src_hwrite;
  assign pass  = m_ok & resv_valid_q[m] & (resv_gran_q[m] == g);
  // A bus error on an exclusive read must not leave a reservation behind
  assign err_clr = dp_active_q & dp_excl_rd_q & ~dp_local_q & dst_hresp;

  assign dst_hready = src_hready;
  assign dst_haddr  = src_haddr;
  assign dst_hwrite = src_hwrite;
  assign dst_htrans = (ex_wr & ~pass) ? 2'b00 : src_htrans;
  assign dst_hsize  = src_hsize;
  assign dst_hprot  = src_hprot;
  assign dst_hwdata = src_hwdata;

  assign src_hrdata      = dst_hrdata;
  assign src_hready_resp = dp_local_q ? 1'b1 : dst_hready_resp;
  assign src_hresp       = dp_local_q ? 1'b0 : dst_hresp;
  assign src_hexokay     = ~dp_local_q & dp_excl_ok_q & ~dst_hresp & dst_hready_resp;

  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_gran_d  = resv_gran_q;
    if (err_clr) resv_valid_d[dp_master_q] = 1'b0;
    for (int k = 0; k < N_MASTERS; k++)
      if ((nm_wr | (ex_wr & pass)) && resv_gran_q[k] == g) resv_valid_d[k] = 1'b0;
    if (ex_wr & ~pass & m_ok) resv_valid_d[m] = 1'b0;
    // Placed last so a new reservation beats a same-cycle error clear
    if (ex_rd & m_ok) begin
      resv_valid_d[m] = 1'b1;
      resv_gran_d[m]  = g;
    end
  end

  assign dp_active_d  = src_hready ? src_htrans[1]               : dp_active_q;
  assign dp_local_d   = src_hready ? ex_wr & ~pass               : dp_local_q;
  assign dp_excl_ok_d = src_hready ? (ex_rd & m_ok) | (ex_wr & pass) : dp_excl_ok_q;
  assign dp_excl_rd_d = src_hready ? ex_rd & m_ok                : dp_excl_rd_q;
  assign dp_master_d  = src_hready ? m                           : dp_master_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid_q <= '0;
      resv_gran_q  <= '{default: '0};
      dp_active_q  <= 1'b0;
      dp_local_q   <= 1'b0;
      dp_excl_ok_q <= 1'b0;
      dp_excl_rd_q <= 1'b0;
      dp_master_q  <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_gran_q  <= resv_gran_d;
      dp_active_q  <= dp_active_d;
      dp_local_q   <= dp_local_d;
      dp_excl_ok_q <= dp_excl_ok_d;
      dp_excl_rd_q <= dp_excl_rd_d;
      dp_master_q  <= dp_master_d;
    end
  end
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// tb_ahbl_excl_monitor: directed bench with a reservation/memory model and a per-cycle compare process.
// A small memory slave sits behind the monitor so suppressed stores can be observed on read-back.
module tb_ahbl_excl_monitor;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        src_hready, src_hready_resp, src_hresp, src_hwrite, src_hexcl, src_hexokay;
  logic [31:0] src_haddr, src_hwdata, src_hrdata, dst_haddr, dst_hwdata, dst_hrdata;
  logic [1:0]  src_htrans, dst_htrans;
  logic [2:0]  src_hsize, dst_hsize;
  logic [3:0]  src_hprot, dst_hprot;
  logic [7:0]  src_hmaster;
  logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite;

  always #5 clk = ~clk;

  ahbl_excl_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hprot(src_hprot), .src_hwdata(src_hwdata),
    .src_hrdata(src_hrdata), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster),
    .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hprot(dst_hprot), .dst_hwdata(dst_hwdata),
    .dst_hrdata(dst_hrdata)
  );

  // Memory slave: captures accepted address phases, commits writes on OKAY completion
  logic [31:0] mem [0:4095];
  logic        s_act, s_wr;
  logic [31:0] s_addr;
  assign dst_hrdata = mem[s_addr[13:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act <= 1'b0;
    end else begin
      if (s_act && s_wr && dst_hready_resp && !dst_hresp) mem[s_addr[13:2]] = dst_hwdata;
      if (dst_hready) begin
        s_act  <= dst_htrans[1];
        s_wr   <= dst_hwrite;
        s_addr <= dst_haddr;
      end
    end
  end

  int n_checks = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reservation per master as a granule number (-1 = none) plus a reference memory
  int          rsv [2];
  logic [31:0] rmem [0:4095];

  logic        chk_en = 1'b0, exp_ready, exp_resp, exp_okay, exp_tr_en, exp_rd_en;
  logic [1:0]  exp_tr;
  logic [31:0] exp_addr, exp_rdata, last_rdata;
  logic        last_okay, last_tr_idle;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("hready_resp", 32'(src_hready_resp), 32'(exp_ready));
      check("hresp", 32'(src_hresp), 32'(exp_resp));
      check("hexokay", 32'(src_hexokay), 32'(exp_okay));
      last_okay = src_hexokay;
      if (exp_tr_en) begin
        check("dst_htrans", 32'(dst_htrans), 32'(exp_tr));
        check("dst_haddr", dst_haddr, exp_addr);
        last_tr_idle = (dst_htrans == 2'b00);
      end
      if (exp_rd_en) begin
        check("hrdata", src_hrdata, exp_rdata);
        last_rdata = src_hrdata;
      end
    end
  end

  task automatic xfer(input int m, input logic [31:0] a, input bit wr, input bit ex,
                      input logic [31:0] wd, input int waits, input bit err,
                      output logic okay_o, output logic supp_o, output logic [31:0] rd_o);
    bit vm = (m < 2), loc = 0, okx = 0;
    int g = int'(a >> 2);
    if (ex && !wr) begin
      okx = vm;
      if (vm) rsv[m] = g;
    end else if (ex && wr) begin
      if (vm && rsv[m] == g) begin
        okx = 1;
        foreach (rsv[k]) if (rsv[k] == g) rsv[k] = -1;
      end else begin
        loc = 1;
        if (vm) rsv[m] = -1;
      end
    end else if (wr) begin
      foreach (rsv[k]) if (rsv[k] == g) rsv[k] = -1;
    end
    if (wr && !loc && !err) rmem[a[13:2]] = wd;
    @(posedge clk); #1;
    src_hready = 1; src_htrans = 2'b10; src_haddr = a; src_hwrite = wr; src_hexcl = ex;
    src_hmaster = 8'(m); dst_hready_resp = 1; dst_hresp = 0;
    exp_ready = 1; exp_resp = 0; exp_okay = 0; exp_tr_en = 1; exp_tr = loc ? 2'b00 : 2'b10;
    exp_addr = a; exp_rd_en = 0; chk_en = 1;
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hexcl = 0; src_hwdata = wd; exp_tr_en = 0;
    if (!loc) begin
      for (int i = 0; i < waits; i++) begin
        src_hready = 0; dst_hready_resp = 0; exp_ready = 0; exp_okay = 0;
        @(posedge clk); #1;
      end
      if (err) begin
        src_hready = 0; dst_hready_resp = 0; dst_hresp = 1; exp_ready = 0; exp_resp = 1;
        @(posedge clk); #1;
        src_hready = 1; dst_hready_resp = 1;
        exp_ready = 1; exp_resp = 1; exp_okay = 0;
        if (ex && !wr && vm) rsv[m] = -1;
      end else begin
        src_hready = 1; dst_hready_resp = 1; dst_hresp = 0;
        exp_ready = 1; exp_resp = 0; exp_okay = okx;
        exp_rd_en = !wr; exp_rdata = rmem[a[13:2]];
      end
    end else begin
      src_hready = 1; exp_ready = 1; exp_resp = 0; exp_okay = 0;
    end
    @(negedge clk); #1;
    okay_o = last_okay; supp_o = last_tr_idle; rd_o = last_rdata;
  endtask

  initial begin
    logic ok, sp;
    logic [31:0] rd;
    rsv = '{-1, -1};
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      rmem[i] = 32'h0;
    end
    mem[32'h3000 >> 2] = 32'h1234_5678;
    rmem[32'h3000 >> 2] = 32'h1234_5678;
    src_hready = 1; src_htrans = 0; src_haddr = 0; src_hwrite = 0; src_hsize = 3'd2;
    src_hprot = 4'h3; src_hwdata = 0; src_hexcl = 0; src_hmaster = 0;
    dst_hready_resp = 1; dst_hresp = 0;
    #3;
    check("reset_ready", 32'(src_hready_resp), 32'd1);
    check("reset_resp", 32'(src_hresp), 32'd0);
    check("reset_okay", 32'(src_hexokay), 32'd0);
    @(posedge clk); #1 rst_n = 1;

    xfer(0, 32'h1000, 0, 1, 0, 0, 0, ok, sp, rd);
    check("t1_exrd_okay", 32'(ok), 32'd1);
    xfer(0, 32'h1000, 1, 1, 32'hA5, 0, 0, ok, sp, rd);
    check("t1_exwr_okay", 32'(ok), 32'd1);
    check("t1_exwr_fwd", 32'(sp), 32'd0);
    xfer(0, 32'h1000, 1, 1, 32'h5A, 0, 0, ok, sp, rd);
    check("t1_slot_cleared", 32'(sp), 32'd1);

    xfer(0, 32'h1000, 0, 1, 0, 0, 0, ok, sp, rd);
    xfer(1, 32'h1002, 1, 0, 32'hBEEF, 0, 0, ok, sp, rd);
    xfer(0, 32'h1000, 1, 1, 32'hDEAD, 0, 0, ok, sp, rd);
    check("t2_supp", 32'(sp), 32'd1);
    check("t2_okay", 32'(ok), 32'd0);
    xfer(0, 32'h1000, 0, 0, 0, 0, 0, ok, sp, rd);
    check("t2_mem", rd, 32'hBEEF);

    xfer(0, 32'h2000, 0, 1, 0, 0, 0, ok, sp, rd);
    xfer(1, 32'h2000, 0, 1, 0, 0, 0, ok, sp, rd);
    xfer(1, 32'h2000, 1, 1, 32'h11, 0, 0, ok, sp, rd);
    check("t3_m1_okay", 32'(ok), 32'd1);
    xfer(0, 32'h2000, 1, 1, 32'h22, 0, 0, ok, sp, rd);
    check("t3_m0_supp", 32'(sp), 32'd1);

    xfer(0, 32'h3000, 1, 1, 32'h99, 0, 0, ok, sp, rd);
    check("t4_supp", 32'(sp), 32'd1);
    xfer(0, 32'h3000, 0, 0, 0, 0, 0, ok, sp, rd);
    check("t4_mem", rd, 32'h1234_5678);

    xfer(0, 32'h5000, 0, 1, 0, 0, 0, ok, sp, rd);
    xfer(5, 32'h5000, 0, 1, 0, 0, 0, ok, sp, rd);
    check("t5_bad_m_rd_okay", 32'(ok), 32'd0);
    xfer(5, 32'h5000, 1, 1, 32'h55, 0, 0, ok, sp, rd);
    check("t5_bad_m_wr_supp", 32'(sp), 32'd1);
    xfer(0, 32'h5000, 1, 1, 32'h66, 0, 0, ok, sp, rd);
    check("t5_m0_intact", 32'(ok), 32'd1);

    xfer(0, 32'h6000, 0, 1, 0, 0, 0, ok, sp, rd);
    xfer(0, 32'h6000, 1, 1, 32'h77, 3, 0, ok, sp, rd);
    check("t6_wait_okay", 32'(ok), 32'd1);
    xfer(1, 32'h7000, 0, 1, 0, 0, 1, ok, sp, rd);
    check("t6_err_okay", 32'(ok), 32'd0);
    xfer(1, 32'h7000, 1, 1, 32'h88, 0, 0, ok, sp, rd);
    check("t6_err_cleared", 32'(sp), 32'd1);

    xfer(0, 32'h4000, 0, 1, 0, 0, 0, ok, sp, rd);
    chk_en = 0;
    @(posedge clk); #1;
    src_hready = 1; src_htrans = 0; src_haddr = 32'h4000; src_hwrite = 1; src_hexcl = 0;
    xfer(0, 32'h4000, 0, 1, 0, 0, 0, ok, sp, rd);
    @(posedge clk); #1;
    src_htrans = 0; src_hexcl = 0; src_hready = 1; dst_hready_resp = 1;
    chk_en = 0;
    @(posedge clk); #1;
    src_htrans = 2'b10; src_haddr = 32'h4000; src_hwrite = 0; src_hexcl = 1; src_hmaster = 0;
    @(posedge clk); #1;
    src_htrans = 0; src_hexcl = 0; dst_hready_resp = 1;
    #1 check("t7_pre_okay", 32'(src_hexokay), 32'd1);
    rst_n = 0;
    rsv = '{-1, -1};
    #1;
    check("t7_rst_ready", 32'(src_hready_resp), 32'd1);
    check("t7_rst_okay", 32'(src_hexokay), 32'd0);
    @(posedge clk); #1 rst_n = 1;
    xfer(0, 32'h4000, 1, 1, 32'hAA, 0, 0, ok, sp, rd);
    check("t7_after_rst_supp", 32'(sp), 32'd1);

    @(posedge clk); #1;
    src_htrans = 0; chk_en = 0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
